// File: rtl/wb_mem_bist.sv
// Wishbone classic master that writes, reads back and checks a pattern in SDRAM.
// Optional BIST_INVERT_PASS_EN adds a second write/read pass with the inverted pattern.
module wb_mem_bist #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned WORD_COUNT     = 1024,
    parameter logic [31:0] SEED           = 32'hA5A5_5A5A,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    input  logic        init_done_i,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic        timeout_o,
    output logic [15:0] err_count_o,
    output logic [31:0] first_err_addr_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_INIT,
        S_WR_REQ,
        S_WR_GAP,
        S_RD_REQ,
        S_RD_CHK,
        S_DONE
    } state_e;

    localparam logic [15:0] LAST_IDX = 16'(WORD_COUNT - 1);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
`ifdef BIST_INVERT_PASS_EN
    localparam logic INV_EN = 1'b1;
`else
    localparam logic INV_EN = 1'b0;
`endif

    state_e      state_q;
    logic [15:0] idx_q;
    logic [31:0] tmo_q;
    logic [31:0] rdat_q;
    logic        inv_q;
    logic        cyc_q, stb_q, we_q;
    logic [3:0]  sel_q;
    logic [31:0] adr_q, dat_q;
    logic        busy_q, done_q, pass_q, tmo_flag_q;
    logic [15:0] err_q;
    logic [31:0] first_q;

    logic [15:0] idx_d;
    logic        mismatch_d;
    logic [15:0] err_inc_d;
    logic [15:0] err_d;

    function automatic logic [31:0] pat(input logic [15:0] n, input logic inv);
        logic [31:0] p;
        p = SEED ^ {n, ~n};
        return inv ? ~p : p;
    endfunction

    function automatic logic [31:0] addr(input logic [15:0] n);
        return BASE_ADDR + {14'd0, n, 2'b00};
    endfunction

    always_comb begin
        idx_d      = idx_q + 16'd1;
        mismatch_d = (rdat_q != pat(idx_q, inv_q));
        err_inc_d  = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;
        err_d      = mismatch_d ? err_inc_d : err_q;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            tmo_q      <= '0;
            rdat_q     <= '0;
            inv_q      <= 1'b0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            tmo_flag_q <= 1'b0;
            err_q      <= '0;
            first_q    <= '0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        err_q      <= '0;
                        first_q    <= '0;
                        tmo_flag_q <= 1'b0;
                        pass_q     <= 1'b0;
                        done_q     <= 1'b0;
                        busy_q     <= 1'b1;
                        inv_q      <= 1'b0;
                        state_q    <= S_WAIT_INIT;
                    end
                end
                S_WAIT_INIT: begin
                    if (init_done_i) begin
                        idx_q   <= '0;
                        tmo_q   <= '0;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        we_q    <= 1'b1;
                        sel_q   <= 4'hF;
                        adr_q   <= addr(16'd0);
                        dat_q   <= pat(16'd0, 1'b0);
                        state_q <= S_WR_REQ;
                    end
                end
                S_WR_REQ, S_RD_REQ: begin
                    if (wb_ack_i) begin
                        cyc_q <= 1'b0;
                        stb_q <= 1'b0;
                        we_q  <= 1'b0;
                        sel_q <= '0;
                        if (state_q == S_RD_REQ) begin
                            rdat_q  <= wb_dat_i;
                            state_q <= S_RD_CHK;
                        end else begin
                            state_q <= S_WR_GAP;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        // Abandon the transfer; a late ack lands in DONE and is ignored.
                        cyc_q      <= 1'b0;
                        stb_q      <= 1'b0;
                        we_q       <= 1'b0;
                        sel_q      <= '0;
                        tmo_flag_q <= 1'b1;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        pass_q     <= 1'b0;
                        state_q    <= S_DONE;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
                S_WR_GAP: begin
                    tmo_q <= '0;
                    cyc_q <= 1'b1;
                    stb_q <= 1'b1;
                    sel_q <= 4'hF;
                    if (idx_q == LAST_IDX) begin
                        idx_q   <= '0;
                        we_q    <= 1'b0;
                        adr_q   <= addr(16'd0);
                        state_q <= S_RD_REQ;
                    end else begin
                        idx_q   <= idx_d;
                        we_q    <= 1'b1;
                        adr_q   <= addr(idx_d);
                        dat_q   <= pat(idx_d, inv_q);
                        state_q <= S_WR_REQ;
                    end
                end
                S_RD_CHK: begin
                    err_q <= err_d;
                    if (mismatch_d && err_q == 16'd0) begin
                        first_q <= addr(idx_q);
                    end
                    if (idx_q != LAST_IDX) begin
                        idx_q   <= idx_d;
                        tmo_q   <= '0;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        sel_q   <= 4'hF;
                        we_q    <= 1'b0;
                        adr_q   <= addr(idx_d);
                        state_q <= S_RD_REQ;
                    end else if (INV_EN && !inv_q) begin
                        inv_q   <= 1'b1;
                        idx_q   <= '0;
                        tmo_q   <= '0;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        sel_q   <= 4'hF;
                        we_q    <= 1'b1;
                        adr_q   <= addr(16'd0);
                        dat_q   <= pat(16'd0, 1'b1);
                        state_q <= S_WR_REQ;
                    end else begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == 16'd0) && !tmo_flag_q;
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wb_adr_o         = adr_q;
    assign wb_dat_o         = dat_q;
    assign wb_sel_o         = sel_q;
    assign wb_we_o          = we_q;
    assign wb_cyc_o         = cyc_q;
    assign wb_stb_o         = stb_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign timeout_o        = tmo_flag_q;
    assign err_count_o      = err_q;
    assign first_err_addr_o = first_q;

endmodule

// File: tb/tb_wb_mem_bist.sv
// Self-checking bench for wb_mem_bist with a small Wishbone slave model.
// Honours BIST_INVERT_PASS_EN to expect the second inverted pass.
module tb_wb_mem_bist;

    localparam int          WC   = 4;
    localparam logic [31:0] SEED = 32'hA5A5_5A5A;
`ifdef BIST_INVERT_PASS_EN
    localparam int NPASS = 2;
`else
    localparam int NPASS = 1;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic        init_done;
    logic [31:0] wb_adr;
    logic [31:0] wb_dat_w;
    logic [31:0] wb_dat_r;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_ack;
    logic        busy;
    logic        done;
    logic        pass;
    logic        tmo;
    logic [15:0] err_cnt;
    logic [31:0] first_err;

    wb_mem_bist #(
        .BASE_ADDR(32'h0),
        .WORD_COUNT(WC),
        .SEED(SEED),
        .TIMEOUT_CYCLES(256)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .start_i(start),
        .init_done_i(init_done),
        .wb_adr_o(wb_adr),
        .wb_dat_o(wb_dat_w),
        .wb_dat_i(wb_dat_r),
        .wb_sel_o(wb_sel),
        .wb_we_o(wb_we),
        .wb_cyc_o(wb_cyc),
        .wb_stb_o(wb_stb),
        .wb_ack_i(wb_ack),
        .busy_o(busy),
        .done_o(done),
        .pass_o(pass),
        .timeout_o(tmo),
        .err_count_o(err_cnt),
        .first_err_addr_o(first_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
    } xfer_t;

    typedef struct {
        int          mode;
        logic        exp_pass;
        logic [15:0] exp_err;
        logic [31:0] exp_first;
        logic        exp_tmo;
    } vec_t;

    xfer_t       sb[$];
    int          checks = 0;
    int          failures = 0;
    int          mode = 0;
    int          cnt = 0;
    logic [31:0] mem [0:15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_pat(input int i, input bit inv);
        logic [15:0] n;
        logic [31:0] p;
        n = i[15:0];
        p = SEED ^ {n, ~n};
        return inv ? ~p : p;
    endfunction

    task automatic push_expected();
        xfer_t x;
        sb.delete();
        for (int p = 0; p < NPASS; p++) begin
            for (int i = 0; i < WC; i++) begin
                x.adr = 32'(4 * i);
                x.dat = model_pat(i, p == 1);
                x.we  = 1'b1;
                sb.push_back(x);
            end
            for (int i = 0; i < WC; i++) begin
                x.adr = 32'(4 * i);
                x.dat = '0;
                x.we  = 1'b0;
                sb.push_back(x);
            end
        end
    endtask

    // Slave: ack on the third falling edge of a request; mode 1 corrupts reads of 0x8, mode 2 never acks.
    always @(negedge clk) begin
        xfer_t       e;
        logic [31:0] rd;
        if (wb_ack) begin
            wb_ack = 1'b0;
            cnt    = 0;
            chk("stb_gap", {31'd0, wb_stb}, 32'd0);
        end else if (wb_cyc && wb_stb && mode != 2) begin
            cnt++;
            if (cnt == 3) begin
                wb_ack = 1'b1;
                if (sb.size() == 0) begin
                    chk("sb_unexpected_xfer", wb_adr, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("xfer_adr", wb_adr, e.adr);
                    chk("xfer_we", {31'd0, wb_we}, {31'd0, e.we});
                    chk("xfer_sel", {28'd0, wb_sel}, 32'hF);
                    if (e.we) chk("xfer_wdat", wb_dat_w, e.dat);
                end
                if (wb_we) begin
                    mem[wb_adr[5:2]] = wb_dat_w;
                end else begin
                    rd = mem[wb_adr[5:2]];
                    if (mode == 1 && wb_adr == 32'h8) rd[0] = ~rd[0];
                    wb_dat_r = rd;
                end
            end
        end else if (!wb_stb) begin
            cnt = 0;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_stb(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            if (wb_stb) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    vec_t vt[4];

    initial begin
        bit ok;
        int viol;
        int n;

        vt[0] = '{mode: 0, exp_pass: 1'b1, exp_err: 16'd0, exp_first: 32'h0, exp_tmo: 1'b0};
        vt[1] = '{mode: 1, exp_pass: 1'b0, exp_err: 16'(NPASS), exp_first: 32'h8, exp_tmo: 1'b0};
        vt[2] = '{mode: 0, exp_pass: 1'b1, exp_err: 16'd0, exp_first: 32'h0, exp_tmo: 1'b0};
        vt[3] = '{mode: 2, exp_pass: 1'b0, exp_err: 16'd0, exp_first: 32'h0, exp_tmo: 1'b1};

        rst       = 1'b1;
        start     = 1'b0;
        init_done = 1'b1;
        wb_ack    = 1'b0;
        wb_dat_r  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_cyc", {31'd0, wb_cyc}, 32'd0);
        chk("rst_stb", {31'd0, wb_stb}, 32'd0);
        chk("rst_pass", {31'd0, pass}, 32'd0);
        chk("rst_err", {16'd0, err_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 4; k++) begin
            mode = vt[k].mode;
            if (mode != 2) push_expected();
            else sb.delete();
            pulse_start();
            wait_done(ok);
            chk("done_reached", {31'd0, ok}, 32'd1);
            chk("vec_pass", {31'd0, pass}, {31'd0, vt[k].exp_pass});
            chk("vec_err", {16'd0, err_cnt}, {16'd0, vt[k].exp_err});
            chk("vec_first", first_err, vt[k].exp_first);
            chk("vec_tmo", {31'd0, tmo}, {31'd0, vt[k].exp_tmo});
            chk("vec_busy", {31'd0, busy}, 32'd0);
            chk("vec_sb_empty", sb.size(), 32'd0);
        end

        // Timeout timing: stb stays high exactly 256 cycles.
        mode = 2;
        sb.delete();
        pulse_start();
        wait_stb(ok);
        chk("tmo_stb_seen", {31'd0, ok}, 32'd1);
        repeat (255) @(posedge clk);
        #1;
        chk("tmo_stb_at255", {31'd0, wb_stb}, 32'd1);
        @(posedge clk);
        #1;
        chk("tmo_stb_at256", {31'd0, wb_stb}, 32'd0);
        chk("tmo_cyc_at256", {31'd0, wb_cyc}, 32'd0);
        chk("tmo_flag", {31'd0, tmo}, 32'd1);
        chk("tmo_done", {31'd0, done}, 32'd1);
        chk("tmo_pass", {31'd0, pass}, 32'd0);

        // Delayed SDRAM init.
        mode      = 0;
        init_done = 1'b0;
        push_expected();
        pulse_start();
        viol = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (wb_cyc) viol++;
        end
        chk("init_no_cyc", viol, 32'd0);
        @(negedge clk);
        init_done = 1'b1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            n++;
            if (wb_cyc) break;
        end
        chk("init_latency_le2", {31'd0, n <= 2}, 32'd1);
        wait_done(ok);
        chk("init_done_reached", {31'd0, ok}, 32'd1);
        chk("init_pass", {31'd0, pass}, 32'd1);

        // Reset in the middle of a write request.
        push_expected();
        pulse_start();
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            if (wb_stb && wb_we) begin
                ok = 1'b1;
                break;
            end
        end
        chk("mid_wr_seen", {31'd0, ok}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_cyc", {31'd0, wb_cyc}, 32'd0);
        chk("mrst_stb", {31'd0, wb_stb}, 32'd0);
        chk("mrst_we", {31'd0, wb_we}, 32'd0);
        chk("mrst_sel", {28'd0, wb_sel}, 32'd0);
        chk("mrst_adr", wb_adr, 32'd0);
        chk("mrst_dat", wb_dat_w, 32'd0);
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd0);
        chk("mrst_pass", {31'd0, pass}, 32'd0);
        chk("mrst_tmo", {31'd0, tmo}, 32'd0);
        chk("mrst_first", first_err, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push_expected();
        pulse_start();
        wait_done(ok);
        chk("post_rst_done", {31'd0, ok}, 32'd1);
        chk("post_rst_pass", {31'd0, pass}, 32'd1);
        chk("post_rst_err", {16'd0, err_cnt}, 32'd0);
        chk("post_rst_sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
